multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback.
//  Drives the datapath strobes that latch the instruction register; the immediate generator decodes from that register.
//  Also drives PC update, ALU operand select, register-file write and writeback select.
//  Handshakes with instruction and data memory; detects illegal opcodes and memory timeouts.
// PARAMETERS
//  TIMEOUT  15  max cycles a memory req may stay unacknowledged before fault (>=1)
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  synchronous reset, active-high
//  opcode       in   7  inst[6:0] from instruction register (stable from DECODE to end of instruction)
//  branch_taken in   1  branch compare result from ALU, valid in EXEC
//  imem_ack     in   1  instruction memory ack, single-cycle pulse
//  dmem_ack     in   1  data memory ack, single-cycle pulse
//  imem_req     out  1  instruction fetch request
//  dmem_req     out  1  data memory request
//  dmem_we      out  1  data memory write (store), valid with dmem_req
//  ir_we        out  1  instruction register load enable
//  pc_we        out  1  PC write enable
//  pc_sel       out  1  0: PC+4, 1: PC+imm
//  alu_src_imm  out  1  ALU operand B = imm (1) or rs2 (0)
//  reg_we       out  1  register file write enable
//  wb_sel       out  1  writeback source: 0 ALU, 1 memory
//  instret      out  1  one-cycle pulse per retired instruction (= pc_we)
//  state_o      out  3  current state encoding
//  fault        out  1  sticky fault flag
//  fault_code   out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 FAULT=7. Registered state; outputs decoded from state plus ack (Mealy on ack).
//  Reset: on a rst edge -> state FETCH, timeout counter 0, fault 0, fault_code 00.
//   During the rst cycle all outputs are 0. Mid-instruction reset aborts with no pc_we/reg_we.
//  Legal opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
//  FETCH: imem_req=1. On imem_ack=1: ir_we=1 that cycle, next DECODE. Otherwise stay.
//  DECODE: 1 cycle, no strobes. Legal -> EXEC. Illegal -> FAULT with code 01.
//  EXEC: alu_src_imm=1 for I-ALU/LOAD/STORE, 0 for R/BRANCH. Next-state by opcode:
//   BRANCH: pc_we=1, pc_sel=branch_taken, next FETCH.
//   R/I-ALU: next WB.
//   LOAD/STORE: next MEM.
//  MEM: dmem_req=1, dmem_we=(STORE), alu_src_imm=1. On dmem_ack: STORE -> pc_we=1, pc_sel=0, next FETCH.
//   On dmem_ack for LOAD -> next WB.
//  WB: reg_we=1, wb_sel=(LOAD), pc_we=1, pc_sel=0, next FETCH.
//  Cycle counts with zero-wait ack: BRANCH 3, R/I 4, STORE 4, LOAD 5.
//  Timeout: counter cleared on every state entry; increments each FETCH/MEM cycle without ack.
//   Counter width = clog2(TIMEOUT+1).
//   If counter==TIMEOUT and no ack -> FAULT, code 10 (FETCH) or 11 (MEM). Ack in that same cycle wins; no fault.
//  FAULT: all strobes/reqs 0; sticky until rst; fault_code held.
//  Acks arriving in states not awaiting them are ignored. Only one req is ever asserted at a time.
//  instret == pc_we exactly; pc_sel=0 whenever pc_we=0.
// TESTING
//  1. addi (0010011), imem_ack/dmem_ack at first req cycle -> states 0,1,2,4.
//     ir_we @c0; alu_src_imm @c2; reg_we, pc_we, instret @c3.
//  2. lw (0000011), dmem_ack 2 cycles late -> MEM lasts 3 cycles, dmem_we=0.
//     WB has reg_we=1, wb_sel=1; 7 cycles total.
//  3. beq (1100011), branch_taken=1 then 0 -> EXEC pc_we=1 with pc_sel=1, then pc_sel=0; reg_we never 1.
//  4. opcode 1111111 -> DECODE->FAULT, fault=1, code 01; later imem_ack pulses ignored, imem_req stays 0.
//  5. TIMEOUT=15, imem_ack withheld -> FAULT code 10 exactly after counter reaches 15.
//     Repeat with ack in that cycle -> no fault, DECODE.
//  6. rst asserted in MEM of a store -> no pc_we/reg_we; next cycle state 0, imem_req=1, fault=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle sequencer with illegal-opcode and memory-timeout fault detection
module multicycle_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       alu_src_imm,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       instret,
    output logic [2:0] state_o,
    output logic       fault,
    output logic [1:0] fault_code
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd7
    } state_t;
    state_t state, next;
    logic [CW-1:0] cnt;
    logic [1:0] code, next_code;
    logic is_r, is_i, is_ld, is_st, is_br, legal, expired;
    assign is_r    = opcode == 7'b0110011;
    assign is_i    = opcode == 7'b0010011;
    assign is_ld   = opcode == 7'b0000011;
    assign is_st   = opcode == 7'b0100011;
    assign is_br   = opcode == 7'b1100011;
    assign legal   = is_r | is_i | is_ld | is_st | is_br;
    assign expired = cnt == CW'(TIMEOUT);
    always_comb begin
        next = state;
        next_code = code;
        {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_imm, reg_we, wb_sel} = 9'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                ir_we = imem_ack;
                next = imem_ack ? DECODE : expired ? FAULT : FETCH;
                next_code = !imem_ack && expired ? 2'b10 : code;
            end
            DECODE: begin
                next = legal ? EXEC : FAULT;
                next_code = legal ? code : 2'b01;
            end
            EXEC: begin
                alu_src_imm = is_i | is_ld | is_st;
                pc_we = is_br;
                pc_sel = is_br & branch_taken;
                next = is_br ? FETCH : (is_ld | is_st) ? MEM : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we = is_st;
                alu_src_imm = 1'b1;
                pc_we = dmem_ack & is_st;
                next = dmem_ack ? (is_st ? FETCH : WB) : expired ? FAULT : MEM;
                next_code = !dmem_ack && expired ? 2'b11 : code;
            end
            WB: begin
                reg_we = 1'b1;
                wb_sel = is_ld;
                pc_we = 1'b1;
                next = FETCH;
            end
            FAULT: next = FAULT;
            default: next = FETCH;
        endcase
        // Reset cycle forces every strobe low so an aborted instruction never commits
        if (rst) {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_imm, reg_we, wb_sel} = 9'b0;
    end
    assign instret    = pc_we;
    assign state_o    = rst ? 3'd0 : state;
    assign fault      = !rst && state == FAULT;
    assign fault_code = rst ? 2'b00 : code;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            cnt <= '0;
            code <= 2'b00;
        end else begin
            state <= next;
            code <= next_code;
            cnt <= next != state ? '0 : (state == FETCH || state == MEM) ? cnt + 1'b1 : cnt;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle scoreboard of multicycle_ctrl against an instruction-level trace model
module tb_multicycle_ctrl;
    localparam int TO = 15;
    logic clk = 1'b0, rst = 1'b1;
    logic [6:0] opcode = '0;
    logic branch_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_imm, reg_we, wb_sel, instret, fault;
    logic [2:0] state_o;
    logic [1:0] fault_code;
    logic [15:0] got, mon_e;
    typedef struct packed {logic r; logic [6:0] op; logic bt; logic ia; logic da;} stim_t;
    stim_t ps[$];
    logic [15:0] pe[$];
    logic [15:0] exp_q[$];
    int errors = 0, checks = 0, n, abort_at;
    bit dead;

    multicycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src_imm(alu_src_imm), .reg_we(reg_we), .wb_sel(wb_sel), .instret(instret),
        .state_o(state_o), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;
    assign got = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_imm, reg_we, wb_sel,
                  instret, state_o, fault, fault_code};

    function automatic logic rb();
        return $urandom_range(0, 3) == 0;
    endfunction

    // Expected output word: retirement is pc_we, fault flag follows the FAULT state
    function automatic logic [15:0] ev(input logic [2:0] s, input logic imr, dmr, dwe, irw, pcw, pcs, alu, rw, wbs,
                                       input logic [1:0] fc);
        return {imr, dmr, dwe, irw, pcw, pcs, alu, rw, wbs, pcw, s, s == 3'd7, fc};
    endfunction

    task automatic cyc(input logic ia, da, bt, input logic [6:0] op, input logic [15:0] e);
        if (dead) return;
        if (n == abort_at) begin
            ps.push_back({1'b1, op, bt, ia, da});
            pe.push_back(16'h0);
            dead = 1;
            return;
        end
        ps.push_back({1'b0, op, bt, ia, da});
        pe.push_back(e);
        n++;
    endtask

    task automatic rst_cyc(input logic [6:0] op);
        ps.push_back({1'b1, op, rb(), rb(), rb()});
        pe.push_back(16'h0);
    endtask

    task automatic fault_tail(input logic [6:0] op, input logic [1:0] fc);
        for (int i = 0; i < 5; i++) cyc(rb(), rb(), rb(), op, ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, fc));
        if (!dead) rst_cyc(op);
    endtask

    task automatic gen(input logic [6:0] op, input int iw, input int dw, input logic bt, input int ab);
        logic isr, isi, isl, iss, isb;
        isr = op == 7'b0110011;
        isi = op == 7'b0010011;
        isl = op == 7'b0000011;
        iss = op == 7'b0100011;
        isb = op == 7'b1100011;
        n = 0;
        dead = 0;
        abort_at = ab;
        for (int i = 0; i < (iw > TO ? TO + 1 : iw); i++) cyc(0, rb(), rb(), op, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (iw > TO) begin
            fault_tail(op, 2'b10);
            return;
        end
        cyc(1, rb(), rb(), op, ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        cyc(rb(), rb(), rb(), op, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (!(isr | isi | isl | iss | isb)) begin
            fault_tail(op, 2'b01);
            return;
        end
        cyc(rb(), rb(), bt, op, ev(2, 0, 0, 0, 0, isb, isb & bt, isi | isl | iss, 0, 0, 0));
        if (isb) return;
        if (isl | iss) begin
            for (int i = 0; i < (dw > TO ? TO + 1 : dw); i++) cyc(rb(), 0, rb(), op, ev(3, 0, 1, iss, 0, 0, 0, 1, 0, 0, 0));
            if (dw > TO) begin
                fault_tail(op, 2'b11);
                return;
            end
            cyc(rb(), 1, rb(), op, ev(3, 0, 1, iss, 0, iss, 0, 1, 0, 0, 0));
            if (iss) return;
        end
        cyc(rb(), rb(), rb(), op, ev(4, 0, 0, 0, 0, 1, 0, 0, 1, isl, 0));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (got !== mon_e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got=%h want=%h (state got=%0d want=%0d)",
                         $time, got, mon_e, got[5:3], mon_e[5:3]);
            end
        end
    end

    initial begin
        logic [6:0] ops [5];
        stim_t s;
        logic [15:0] e;
        int k;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        rst_cyc(0);
        rst_cyc(0);
        gen(7'b0010011, 0, 0, 0, -1);
        gen(7'b0000011, 0, 2, 0, -1);
        gen(7'b1100011, 0, 0, 1, -1);
        gen(7'b1100011, 0, 0, 0, -1);
        gen(7'b0110011, 1, 0, 1, -1);
        gen(7'b0100011, 0, 0, 0, -1);
        gen(7'b1111111, 0, 0, 0, -1);
        gen(7'b0010011, 16, 0, 0, -1);
        gen(7'b0010011, 15, 0, 0, -1);
        gen(7'b0000011, 0, 16, 0, -1);
        gen(7'b0100011, 0, 15, 0, -1);
        gen(7'b0100011, 0, 3, 0, 3);
        for (int t = 0; t < 250; t++) begin
            k = $urandom_range(0, 9);
            gen(k < 5 ? ops[k] : k < 8 ? ops[$urandom_range(0, 4)] : 7'($urandom),
                $urandom_range(0, 9) == 0 ? $urandom_range(14, 16) : $urandom_range(0, 3),
                $urandom_range(0, 9) == 0 ? $urandom_range(14, 16) : $urandom_range(0, 3),
                1'($urandom), $urandom_range(0, 19) == 0 ? $urandom_range(0, 6) : -1);
        end
        while (ps.size() > 0) begin
            s = ps.pop_front();
            e = pe.pop_front();
            @(posedge clk);
            #1;
            rst = s.r;
            opcode = s.op;
            branch_taken = s.bt;
            imem_ack = s.ia;
            dmem_ack = s.da;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
